// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the sMIPS core.
// Owns the program counter, addresses imem directly (zero-latency read) and
// captures the returned word into the IF/ID pipeline register. Decode
// back-pressure stalls the stage. EX-stage redirects flush and retarget it.
// A BREAK instruction is issued and then parks fetch until the next redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] BREAK_INST = 32'h0000_000D
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        halted,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetchState_t;

    fetchState_t r_state;
    fetchState_t w_stateNext;

    logic [31:0] r_pc;
    logic        r_idValid;
    logic [31:0] r_idPc;
    logic [31:0] r_idInst;
    logic        r_halted;
    logic        r_addrErr;

    logic        w_redirect;
    logic        w_issue;
    logic        w_issueBreak;
    logic [31:0] w_redirectPc;
    logic        w_redirectMisaligned;
    logic [31:0] w_pcPlus4;

    // A redirect arriving while still booting is dropped, so the first fetch
    // always comes from RESET_PC. It also beats both issue and stall.
    assign w_redirect           = redirect_valid && (r_state != BOOT);
    assign w_issue              = (r_state == RUN) && (!r_idValid || id_ready) && !redirect_valid;
    assign w_issueBreak         = w_issue && (imem_inst == BREAK_INST);
    assign w_redirectPc         = {redirect_target[31:2], 2'b00};
    assign w_redirectMisaligned = |redirect_target[1:0];
    assign w_pcPlus4            = r_pc + 32'd4;

    // The PC drives imem without a register stage. Every other output is a flop.
    assign imem_addr = r_pc;
    assign id_valid  = r_idValid;
    assign id_pc     = r_idPc;
    assign id_inst   = r_idInst;
    assign halted    = r_halted;
    assign addr_err  = r_addrErr;

    // Next-state logic. BOOT lasts exactly one edge. HALT is left only by a redirect.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            BOOT: begin
                w_stateNext = RUN;
            end
            RUN: begin
                if (w_redirect) begin
                    w_stateNext = RUN;
                end else if (w_issueBreak) begin
                    w_stateNext = HALT;
                end
            end
            HALT: begin
                if (w_redirect) begin
                    w_stateNext = RUN;
                end
            end
            default: begin
                w_stateNext = BOOT;
            end
        endcase
    end

    // State register. The halted flag is registered alongside it so that it tracks HALT exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= BOOT;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_halted <= (w_stateNext == HALT);
        end
    end

    // PC and IF/ID register. The priority order is redirect, then issue, then drain, then hold (stall).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_idValid <= 1'b0;
            r_idPc    <= 32'd0;
            r_idInst  <= 32'd0;
            r_addrErr <= 1'b0;
        end else if (w_redirect) begin
            r_pc      <= w_redirectPc;
            r_idValid <= 1'b0;
            r_addrErr <= w_redirectMisaligned;
        end else begin
            r_addrErr <= 1'b0;
            if (w_issue) begin
                r_pc      <= w_pcPlus4;
                r_idPc    <= r_pc;
                r_idInst  <= imem_inst;
                r_idValid <= 1'b1;
            end else if (id_ready) begin
                r_idValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// A behavioural imem returns a word derived from the address. It can also plant
// a BREAK at one chosen address. Every expected value is worked out by hand.
module tb_fetch_stage;

    localparam logic [31:0] BREAK_WORD = 32'h0000_000D;
    localparam logic [31:0] IMEM_KEY   = 32'h1234_5678;

    logic        clk;
    logic        rst;
    logic [31:0] imemAddr;
    logic [31:0] imemInst;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        idReady;
    logic        idValid;
    logic [31:0] idPc;
    logic [31:0] idInst;
    logic        halted;
    logic        addrErr;

    logic        breakEnable;
    logic [31:0] breakAddr;

    int checkCount;
    int errorCount;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .BREAK_INST (BREAK_WORD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imemAddr),
        .imem_inst       (imemInst),
        .redirect_valid  (redirectValid),
        .redirect_target (redirectTarget),
        .id_ready        (idReady),
        .id_valid        (idValid),
        .id_pc           (idPc),
        .id_inst         (idInst),
        .halted          (halted),
        .addr_err        (addrErr)
    );

    // Free-running clock. Rising edges fall at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word-addressed imem with zero-cycle latency and an optional planted BREAK.
    always_comb begin
        imemInst = imemAddr ^ IMEM_KEY;
        if (breakEnable && (imemAddr == breakAddr)) begin
            imemInst = BREAK_WORD;
        end
    end

    function automatic logic [31:0] wordAt(input logic [31:0] addr);
        return addr ^ IMEM_KEY;
    endfunction

    // Count the comparison, and report it if the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Drive the redirect and decode-ready inputs.
    task automatic applyStimulus(input logic valid, input logic [31:0] target, input logic ready);
        redirectValid  = valid;
        redirectTarget = target;
        idReady        = ready;
    endtask

    // Move one rising edge forward, then settle 1 time unit past it before any sampling.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Check the IF/ID register outputs and the PC on imem_addr.
    task automatic checkState(input string tag, input logic valid, input logic [31:0] pcId,
                              input logic [31:0] inst, input logic [31:0] pcNow);
        checkOutput({tag, ".id_valid"}, {31'd0, idValid}, {31'd0, valid});
        if (valid) begin
            checkOutput({tag, ".id_pc"}, idPc, pcId);
            checkOutput({tag, ".id_inst"}, idInst, inst);
        end
        checkOutput({tag, ".pc"}, imemAddr, pcNow);
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        breakEnable = 1'b0;
        breakAddr   = 32'd0;
        rst         = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b1);

        // Values held while reset is asserted.
        #12;
        checkOutput("rst.id_valid", {31'd0, idValid}, 32'd0);
        checkOutput("rst.id_pc", idPc, 32'd0);
        checkOutput("rst.id_inst", idInst, 32'd0);
        checkOutput("rst.halted", {31'd0, halted}, 32'd0);
        checkOutput("rst.addr_err", {31'd0, addrErr}, 32'd0);
        checkOutput("rst.pc", imemAddr, 32'd0);
        rst = 1'b1;

        // BOOT takes one edge with no fetch. After that, one instruction per edge.
        stepCycle();
        checkState("boot", 1'b0, 32'd0, 32'd0, 32'h0);
        stepCycle();
        checkState("run0", 1'b1, 32'h0, wordAt(32'h0), 32'h4);
        stepCycle();
        checkState("run1", 1'b1, 32'h4, wordAt(32'h4), 32'h8);
        stepCycle();
        checkState("run2", 1'b1, 32'h8, wordAt(32'h8), 32'hC);

        // Three stall cycles while id_pc=8 hold everything in place.
        applyStimulus(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkState("stall", 1'b1, 32'h8, wordAt(32'h8), 32'hC);
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        stepCycle();
        checkState("unstall", 1'b1, 32'hC, wordAt(32'hC), 32'h10);

        // A redirect during a stall flushes the IF/ID register even though decode is not ready.
        applyStimulus(1'b0, 32'd0, 1'b0);
        stepCycle();
        checkState("stall2", 1'b1, 32'hC, wordAt(32'hC), 32'h10);
        applyStimulus(1'b1, 32'h0000_0040, 1'b0);
        stepCycle();
        checkState("redir40", 1'b0, 32'd0, 32'd0, 32'h40);
        checkOutput("redir40.addr_err", {31'd0, addrErr}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        stepCycle();
        checkState("after40", 1'b1, 32'h40, wordAt(32'h40), 32'h44);

        // A BREAK at 0x14 is issued, then fetch parks with the PC at 0x18.
        breakAddr   = 32'h14;
        breakEnable = 1'b1;
        applyStimulus(1'b1, 32'h0000_0010, 1'b1);
        stepCycle();
        checkState("redir10", 1'b0, 32'd0, 32'd0, 32'h10);
        applyStimulus(1'b0, 32'd0, 1'b1);
        stepCycle();
        checkState("fetch10", 1'b1, 32'h10, wordAt(32'h10), 32'h14);
        checkOutput("fetch10.halted", {31'd0, halted}, 32'd0);
        stepCycle();
        checkState("break", 1'b1, 32'h14, BREAK_WORD, 32'h18);
        checkOutput("break.halted", {31'd0, halted}, 32'd1);
        stepCycle();
        checkState("halt1", 1'b0, 32'd0, 32'd0, 32'h18);
        checkOutput("halt1.halted", {31'd0, halted}, 32'd1);
        stepCycle();
        checkState("halt2", 1'b0, 32'd0, 32'd0, 32'h18);
        checkOutput("halt2.halted", {31'd0, halted}, 32'd1);
        breakEnable = 1'b0;
        applyStimulus(1'b1, 32'h0000_0000, 1'b1);
        stepCycle();
        checkState("unhalt", 1'b0, 32'd0, 32'd0, 32'h0);
        checkOutput("unhalt.halted", {31'd0, halted}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        stepCycle();
        checkState("resume", 1'b1, 32'h0, wordAt(32'h0), 32'h4);

        // A misaligned redirect that coincides with a BREAK on imem: the redirect wins and addr_err pulses.
        breakAddr   = 32'h4;
        breakEnable = 1'b1;
        applyStimulus(1'b1, 32'h0000_0046, 1'b1);
        stepCycle();
        checkState("redir46", 1'b0, 32'd0, 32'd0, 32'h44);
        checkOutput("redir46.addr_err", {31'd0, addrErr}, 32'd1);
        checkOutput("redir46.halted", {31'd0, halted}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        stepCycle();
        checkState("after46", 1'b1, 32'h44, wordAt(32'h44), 32'h48);
        checkOutput("after46.addr_err", {31'd0, addrErr}, 32'd0);
        checkOutput("after46.halted", {31'd0, halted}, 32'd0);
        breakEnable = 1'b0;

        // The PC wraps from the top of the address space to zero.
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
        stepCycle();
        checkState("redirTop", 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'd0, 1'b1);
        stepCycle();
        checkState("fetchTop", 1'b1, 32'hFFFF_FFFC, wordAt(32'hFFFF_FFFC), 32'h0);
        stepCycle();
        checkState("wrap", 1'b1, 32'h0, wordAt(32'h0), 32'h4);

        // An asynchronous reset in the middle of a cycle clears state without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async.id_valid", {31'd0, idValid}, 32'd0);
        checkOutput("async.pc", imemAddr, 32'd0);
        checkOutput("async.id_pc", idPc, 32'd0);
        stepCycle();
        checkOutput("async.hold.pc", imemAddr, 32'd0);
        #2;
        rst = 1'b1;

        // A redirect during BOOT is ignored, so the first fetch still comes from RESET_PC.
        applyStimulus(1'b1, 32'h0000_0080, 1'b1);
        stepCycle();
        checkState("bootRedir", 1'b0, 32'd0, 32'd0, 32'h0);
        checkOutput("bootRedir.addr_err", {31'd0, addrErr}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        stepCycle();
        checkState("reboot0", 1'b1, 32'h0, wordAt(32'h0), 32'h4);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
